pipe_hazard_ctrl: RTL

//  Central stall/flush sequencer for the 5-stage RISC-V pipeline. Generates write enables and

---
 rtl/pipe_hazard_ctrl.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Stall/flush sequencer for a 5-stage pipeline: load-use stalls, taken-branch squashes,
// and a pipe freeze while a multi-cycle data-memory access waits for its ack.
module pipe_hazard_ctrl #(
  parameter int MEM_TIMEOUT = 16,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       id_rs1,
  input  logic [4:0]       id_rs2,
  input  logic             id_use_rs1,
  input  logic             id_use_rs2,
  input  logic             ex_memRead,
  input  logic [4:0]       ex_rd,
  input  logic             mem_branch,
  input  logic             mem_alu_zero,
  input  logic             mem_memRead,
  input  logic             mem_memWrite,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             pc_sel_branch,
  output logic             if_id_write,
  output logic             id_ex_write,
  output logic             ex_mem_write,
  output logic             mem_wb_write,
  output logic             if_id_flush,
  output logic             id_ex_flush,
  output logic             ex_mem_flush,
  output logic             dmem_req,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt,
  output logic [0:0]       dbg_state
);

  // dmem_req/dmem_ack: req rises with a MEM-stage memop and stays high every cycle
  // until the cycle in which ack is seen (or the timeout cycle); the access is
  // complete in any cycle where req and ack are both high.

  localparam logic [0:0] ST_RUN      = 1'b0;
  localparam logic [0:0] ST_MEM_WAIT = 1'b1;

  localparam int WCW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [WCW-1:0] WAIT_LAST = WCW'(MEM_TIMEOUT - 1);

  logic [0:0]       state_q, state_d;
  logic [WCW-1:0]   wait_cnt_q, wait_cnt_d;
  logic             mem_err_q, mem_err_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic memop, load_use, taken, advance;

  assign memop    = mem_memRead | mem_memWrite;
  assign taken    = mem_branch & mem_alu_zero;
  assign load_use = ex_memRead & (ex_rd != 5'd0) &
                    ((id_use_rs1 & (id_rs1 == ex_rd)) | (id_use_rs2 & (id_rs2 == ex_rd)));

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_err_d     = mem_err_q;
    advance       = 1'b0;
    pc_write      = 1'b0;
    pc_sel_branch = 1'b0;
    if_id_write   = 1'b0;
    id_ex_write   = 1'b0;
    ex_mem_write  = 1'b0;
    mem_wb_write  = 1'b0;
    if_id_flush   = 1'b0;
    id_ex_flush   = 1'b0;
    ex_mem_flush  = 1'b0;
    dmem_req      = 1'b0;

    case (state_q)
      ST_RUN: begin
        if (memop && !dmem_ack) begin
          dmem_req   = 1'b1;
          state_d    = ST_MEM_WAIT;
          wait_cnt_d = WCW'(1);
        end else begin
          dmem_req = memop;
          advance  = 1'b1;
        end
      end
      ST_MEM_WAIT: begin
        dmem_req = 1'b1;
        if (dmem_ack) begin
          advance    = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else if (wait_cnt_q == WAIT_LAST) begin
          // Give up on the access: release the pipe and flag it permanently.
          mem_err_d  = 1'b1;
          advance    = 1'b1;
          state_d    = ST_RUN;
          wait_cnt_d = '0;
        end else begin
          wait_cnt_d = wait_cnt_q + WCW'(1);
        end
      end
      default: begin
        state_d    = ST_RUN;
        wait_cnt_d = '0;
      end
    endcase

    if (advance) begin
      if (taken) begin
        // The load-use victim is on the wrong path, so the branch wins.
        pc_sel_branch = 1'b1;
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;
        if_id_flush   = 1'b1;
        id_ex_flush   = 1'b1;
        ex_mem_flush  = 1'b1;
      end else if (load_use) begin
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;
        id_ex_flush   = 1'b1;
      end else begin
        pc_write      = 1'b1;
        if_id_write   = 1'b1;
        id_ex_write   = 1'b1;
        ex_mem_write  = 1'b1;
        mem_wb_write  = 1'b1;
      end
    end

    if (!reset) begin
      pc_write      = 1'b0;
      pc_sel_branch = 1'b0;
      if_id_write   = 1'b0;
      id_ex_write   = 1'b0;
      ex_mem_write  = 1'b0;
      mem_wb_write  = 1'b0;
      if_id_flush   = 1'b0;
      id_ex_flush   = 1'b0;
      ex_mem_flush  = 1'b0;
      dmem_req      = 1'b0;
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!pc_write && (stall_cnt_q != {CNT_W{1'b1}}))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (pc_sel_branch && (flush_cnt_q != {CNT_W{1'b1}}))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= ST_RUN;
      wait_cnt_q  <= '0;
      mem_err_q   <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      mem_err_q   <= mem_err_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign mem_err   = mem_err_q;
  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;
  assign dbg_state = state_q;

endmodule
